// File: rtl/tdc_pulse_width_tile_pkg.sv
`default_nettype none
// ==== tdc_tile_pkg : shared widths, saturation value and FSM encoding ==== rev 1.0
package tdc_tile_pkg;

  localparam int              RES_W   = 7;
  localparam logic [RES_W-1:0] RES_SAT = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } tdc_state_e;

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_ARMED   = 2'(ST_ARMED);
  localparam logic [1:0] S_MEASURE = 2'(ST_MEASURE);

endpackage
`default_nettype wire

// File: rtl/tdc_pulse_width_tile_if.sv
`default_nettype none
// ==== tdc_pulse_width_tile_if : tile pad bus (ui_in / uo_out) ==== rev 1.0
interface tdc_pulse_width_tile_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ui_in, input uo_out);
  modport slave  (input ui_in, output uo_out);
endinterface
`default_nettype wire

// File: rtl/tdc_pulse_width_tile_sync.sv
`default_nettype none
// ==== sync_edge_detect : two-flop synchronizer, edge register, fill flag ==== rev 1.0
module sync_edge_detect
  import tdc_tile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic       meta;
  logic       s_d;
  logic [1:0] fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
      fill <= 2'd0;
    end else begin
      meta <= din;
      s    <= meta;
      s_d  <= s;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  // s only reflects the live pin once two edges have passed since reset
  assign ready = (fill == 2'd2);
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;

endmodule
`default_nettype wire

// File: rtl/tdc_pulse_width_tile.sv
`default_nettype none
// ==== tdc_pulse_width_tile : measures ui_in[0] high width in 2^PRE_LOG2-cycle ticks ==== rev 1.0
module tdc_pulse_width_tile
  import tdc_tile_pkg::*;
#(
  parameter int PRE_LOG2 = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  tdc_pulse_width_tile_if.slave  pads
);

  // The rise cycle is itself the first high cycle, so it is counted on load
  localparam logic [RES_W-1:0] COUNT_LOAD = (PRE_LOG2 == 0) ? RES_W'(1) : '0;

  logic             s;
  logic             rise;
  logic             fall;
  logic             ready;
  logic [1:0]       state;
  logic [RES_W-1:0] count;
  logic [RES_W-1:0] result;
  logic             toggle;
  logic             tick_wrap;
  logic             unused_ui;

  sync_edge_detect u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pads.ui_in[0]),
    .s     (s),
    .rise  (rise),
    .fall  (fall),
    .ready (ready)
  );

  generate
    if (PRE_LOG2 > 0) begin : g_prescale
      logic [PRE_LOG2-1:0] pre;

      always_ff @(posedge clk) begin
        if (rst) begin
          pre <= '0;
        end else if (state == S_ARMED && rise) begin
          pre <= PRE_LOG2'(1);
        end else if (state == S_MEASURE && !fall) begin
          pre <= pre + 1'b1;
        end
      end

      assign tick_wrap = &pre;
    end else begin : g_no_prescale
      assign tick_wrap = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      result <= '0;
      toggle <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ready && !s) state <= S_ARMED;
        end
        S_ARMED: begin
          if (rise) begin
            state <= S_MEASURE;
            count <= COUNT_LOAD;
          end
        end
        S_MEASURE: begin
          if (fall) begin
            result <= count;
            toggle <= ~toggle;
            state  <= S_ARMED;
          end else if (tick_wrap && count != RES_SAT) begin
            count <= count + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pads.uo_out = {toggle, result};
  assign unused_ui   = |pads.ui_in[7:1];

endmodule
`default_nettype wire

// File: tb/tb_tdc_pulse_width_tile.sv
`default_nettype none
// ==== tb_tdc_pulse_width_tile : random pulse trains vs. a pulse-level reference model ==== rev 1.0
module tb_tdc_pulse_width_tile;

  logic       clk_free = 1'b0;
  logic       clk_en   = 1'b1;
  logic       rst      = 1'b1;
  logic       pin      = 1'b0;
  logic [6:0] junk     = 7'd0;
  wire        gclk     = clk_free & clk_en;

  always #5 clk_free = ~clk_free;

  tdc_pulse_width_tile_if if0 ();
  tdc_pulse_width_tile_if if1 ();
  assign if0.ui_in = {junk, pin};
  assign if1.ui_in = {~junk, pin};

  tdc_pulse_width_tile #(.PRE_LOG2(0)) u_dut0 (.clk(gclk), .rst(rst), .pads(if0));
  tdc_pulse_width_tile #(.PRE_LOG2(2)) u_dut1 (.clk(gclk), .rst(rst), .pads(if1));

  int         n_cmp = 0;
  int         n_mis = 0;
  int         pre_of [2] = '{0, 2};
  logic [7:0] exp_out [2];
  bit         armed;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %02h expected %02h", tag, got, want);
    end
  endtask

  task automatic check_both(input string tag);
    chk({tag, "_p0"}, if0.uo_out, exp_out[0]);
    chk({tag, "_p2"}, if1.uo_out, exp_out[1]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge gclk);
  endtask

  // Width in ticks, clamped at the overflow code
  function automatic logic [6:0] ref_width(input int len, input int p);
    int t;
    t = len / (1 << p);
    return (t > 127) ? 7'd127 : 7'(t);
  endfunction

  task automatic model_pulse(input int len);
    if (armed)
      for (int i = 0; i < 2; i++)
        exp_out[i] = {~exp_out[i][7], ref_width(len, pre_of[i])};
  endtask

  task automatic do_reset(input logic level);
    pin = level;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    exp_out[0] = 8'h00;
    exp_out[1] = 8'h00;
    armed = 1'b0;
  endtask

  task automatic pulse(input int len, input int gap, input string tag);
    junk = 7'($urandom);
    pin  = 1'b1;
    tick(len);
    pin  = 1'b0;
    model_pulse(len);
    tick(gap);
    armed = 1'b1;
    if (gap >= 3) check_both(tag);
  endtask

  initial begin
    int len;
    int gap;

    // Reset with input low, then a 5-cycle pulse with latency check
    do_reset(1'b0);
    check_both("reset");
    tick(4);
    armed = 1'b1;
    pin = 1'b1;
    tick(5);
    pin = 1'b0;
    tick(2);
    check_both("lat_old");
    model_pulse(5);
    tick(1);
    check_both("lat_new");
    chk("first_5", if0.uo_out, 8'h85);
    tick(2);

    pulse(200, 4, "sat200");
    chk("sat_p0", if0.uo_out, 8'h7F);
    pulse(10, 4, "w10");
    pulse(3, 4, "w3");
    pulse(1, 4, "w1");

    // Pulse already high across reset release is never measured
    do_reset(1'b1);
    tick(8);
    pin = 1'b0;
    tick(4);
    armed = 1'b1;
    check_both("held_high");
    pulse(4, 4, "after_held");
    chk("after_held_c", if0.uo_out, 8'h84);

    // Reset mid-pulse discards the partial count
    pulse(5, 4, "pre_rst");
    pin = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_p0", if0.uo_out, 8'h00);
    chk("rst_mid_p2", if1.uo_out, 8'h00);
    tick(1);
    rst = 1'b0;
    exp_out[0] = 8'h00;
    exp_out[1] = 8'h00;
    armed = 1'b0;
    tick(5);
    pin = 1'b0;
    tick(4);
    armed = 1'b1;
    check_both("rst_tail");

    // Clock gated mid-pulse: only clocked high cycles count
    pin = 1'b1;
    tick(3);
    clk_en = 1'b0;
    repeat (5) @(negedge clk_free);
    clk_en = 1'b1;
    tick(3);
    pin = 1'b0;
    model_pulse(6);
    tick(4);
    check_both("gated6");

    // Glitch between clock edges is never sampled
    @(negedge gclk);
    #1 pin = 1'b1;
    #2 pin = 1'b0;
    tick(4);
    check_both("glitch");

    // Back-to-back pulses with a single low cycle between them
    pulse(7, 1, "b2b_a");
    pulse(9, 4, "b2b_b");

    // Random pulse trains
    for (int k = 0; k < 24; k++) begin
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(120, 600) : $urandom_range(1, 40);
      gap = (k == 23) ? 4 : $urandom_range(1, 6);
      pulse(len, gap, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
